// File: rtl/whack_target_judge.sv
`default_nettype none
// ============================================================================
//  Module      : whack_target_judge
//  Description : Round controller for the whack-a-target game. Takes a 1..9
//                value from the random source, lights it as the target,
//                judges the keypad press inside a time window and keeps a
//                two-digit BCD score plus the remaining lives.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock
//    rstn         in   asynchronous active-low reset
//    start        in   single-cycle start request (IDLE / OVER only)
//    rand_num     in   [7:0] random value, usable only when 1..9
//    key_valid    in   single-cycle keypad strobe
//    key_code     in   [3:0] pressed key, sampled with key_valid
//    target       out  [3:0] lit target, 0 when none
//    target_valid out  target lit, window running
//    score_bcd    out  [7:0] BCD score {tens, ones}, saturates at 99
//    lives        out  [1:0] remaining lives
//    hit_pulse    out  one-cycle hit indication
//    miss_pulse   out  one-cycle miss indication (wrong key or timeout)
//    game_over    out  high while the game is over
// ============================================================================
module whack_target_judge #(
  parameter int WINDOW_CYCLES = 50_000_000,
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int START_LIVES   = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] rand_num,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] target,
  output logic       target_valid,
  output logic [7:0] score_bcd,
  output logic [1:0] lives,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  // One counter serves both the SHOW window and the RESULT hold time.
  localparam int c_max_count = (WINDOW_CYCLES > HOLD_CYCLES) ? WINDOW_CYCLES : HOLD_CYCLES;
  localparam int c_cnt_w     = (c_max_count > 1) ? $clog2(c_max_count) : 1;

  localparam logic [c_cnt_w-1:0] c_win_last  = c_cnt_w'(WINDOW_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [1:0]         c_lives_ld  = 2'(START_LIVES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SHOW   = 3'd2,
    ST_RESULT = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]         r_target, w_target_nxt;
  logic [3:0]         r_prev, w_prev_nxt;
  logic               r_target_valid, w_target_valid_nxt;
  logic [7:0]         r_score, w_score_nxt;
  logic [1:0]         r_lives, w_lives_nxt;
  logic               r_hit, w_hit_nxt;
  logic               r_miss, w_miss_nxt;
  logic               r_game_over, w_game_over_nxt;

  // Random value screening and repeat avoidance: a value equal to the
  // previous target is bumped to the next number, 9 wrapping to 1.
  logic [3:0] w_rand_lo;
  logic       w_rand_ok;
  logic [3:0] w_cand;

  assign w_rand_lo = rand_num[3:0];
  assign w_rand_ok = (rand_num[7:4] == 4'd0) && (w_rand_lo != 4'd0) && (w_rand_lo <= 4'd9);
  assign w_cand    = (w_rand_lo != r_prev) ? w_rand_lo :
                     (w_rand_lo == 4'd9)   ? 4'd1 : (w_rand_lo + 4'd1);

  // A key on the expiry cycle takes priority over the timeout.
  logic w_key_hit, w_key_miss, w_timeout, w_judged;

  assign w_key_hit  = key_valid && (key_code == r_target);
  assign w_key_miss = key_valid && (key_code != r_target);
  assign w_timeout  = !key_valid && (r_cnt == c_win_last);
  assign w_judged   = key_valid || w_timeout;

  // Saturating BCD increment.
  logic [7:0] w_score_inc;

  always_comb begin
    w_score_inc = r_score;
    if (r_score != 8'h99) begin
      if (r_score[3:0] == 4'd9) begin
        w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
      end else begin
        w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
      end
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_target_nxt       = r_target;
    w_prev_nxt         = r_prev;
    w_target_valid_nxt = r_target_valid;
    w_score_nxt        = r_score;
    w_lives_nxt        = r_lives;
    w_hit_nxt          = 1'b0;
    w_miss_nxt         = 1'b0;

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          w_score_nxt = 8'h00;
          w_lives_nxt = c_lives_ld;
          w_state_nxt = ST_ARM;
        end
      end

      ST_ARM: begin
        if (w_rand_ok) begin
          w_target_nxt       = w_cand;
          w_prev_nxt         = w_cand;
          w_cnt_nxt          = '0;
          w_target_valid_nxt = 1'b1;
          w_state_nxt        = ST_SHOW;
        end
      end

      ST_SHOW: begin
        w_cnt_nxt = r_cnt + c_cnt_one;
        if (w_key_hit) begin
          w_score_nxt = w_score_inc;
          w_hit_nxt   = 1'b1;
        end
        if (w_key_miss || w_timeout) begin
          w_lives_nxt = r_lives - 2'd1;
          w_miss_nxt  = 1'b1;
        end
        if (w_judged) begin
          w_target_valid_nxt = 1'b0;
          w_target_nxt       = 4'd0;
          w_cnt_nxt          = '0;
          // Losing the last life ends the game.
          w_state_nxt = (!w_key_hit && (r_lives == 2'd1)) ? ST_OVER : ST_RESULT;
        end
      end

      ST_RESULT: begin
        if (r_cnt == c_hold_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ARM;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_game_over_nxt = (w_state_nxt == ST_OVER);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_target       <= 4'd0;
      r_prev         <= 4'd0;
      r_target_valid <= 1'b0;
      r_score        <= 8'h00;
      r_lives        <= 2'd0;
      r_hit          <= 1'b0;
      r_miss         <= 1'b0;
      r_game_over    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_target       <= w_target_nxt;
      r_prev         <= w_prev_nxt;
      r_target_valid <= w_target_valid_nxt;
      r_score        <= w_score_nxt;
      r_lives        <= w_lives_nxt;
      r_hit          <= w_hit_nxt;
      r_miss         <= w_miss_nxt;
      r_game_over    <= w_game_over_nxt;
    end
  end

  assign target       = r_target;
  assign target_valid = r_target_valid;
  assign score_bcd    = r_score;
  assign lives        = r_lives;
  assign hit_pulse    = r_hit;
  assign miss_pulse   = r_miss;
  assign game_over    = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_whack_target_judge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_whack_target_judge
//  Description : Self-checking bench for whack_target_judge. A round-level
//                model (integer score, lives, elapsed-cycle counts) predicts
//                every output each cycle; directed scenarios add literal
//                expectations at the interesting points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_whack_target_judge;

  localparam int WIN   = 8;
  localparam int HOLD  = 4;
  localparam int LIVES = 3;

  // Model phases
  localparam int P_IDLE   = 0;
  localparam int P_ARM    = 1;
  localparam int P_SHOW   = 2;
  localparam int P_RESULT = 3;
  localparam int P_OVER   = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rand_num = 8'd0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [3:0] target;
  logic       target_valid;
  logic [7:0] score_bcd;
  logic [1:0] lives;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  whack_target_judge #(
    .WINDOW_CYCLES(WIN),
    .HOLD_CYCLES  (HOLD),
    .START_LIVES  (LIVES)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .rand_num    (rand_num),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .target      (target),
    .target_valid(target_valid),
    .score_bcd   (score_bcd),
    .lives       (lives),
    .hit_pulse   (hit_pulse),
    .miss_pulse  (miss_pulse),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  int m_phase = P_IDLE;
  int m_target = 0;
  int m_prev = 0;
  int m_score = 0;
  int m_lives = 0;
  int m_age = 0;
  int m_hold = 0;
  int m_hit = 0;
  int m_miss = 0;

  task automatic model_reset();
    m_phase = P_IDLE; m_target = 0; m_prev = 0; m_score = 0;
    m_lives = 0; m_age = 0; m_hold = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic model_step();
    int v;
    m_hit  = 0;
    m_miss = 0;
    case (m_phase)
      P_IDLE, P_OVER: if (start) begin
        m_score = 0; m_lives = LIVES; m_phase = P_ARM;
      end
      P_ARM: begin
        v = int'(rand_num);
        if (v >= 1 && v <= 9) begin
          m_target = (v == m_prev) ? (v % 9) + 1 : v;
          m_prev   = m_target;
          m_age    = 0;
          m_phase  = P_SHOW;
        end
      end
      P_SHOW: begin
        m_age++;
        if (key_valid) begin
          if (int'(key_code) == m_target) m_hit = 1;
          else m_miss = 1;
        end else if (m_age == WIN) begin
          m_miss = 1;
        end
        if (m_hit == 1) m_score = (m_score < 99) ? m_score + 1 : 99;
        if (m_miss == 1) m_lives--;
        if (m_hit == 1 || m_miss == 1) begin
          m_target = 0;
          m_hold   = 0;
          m_phase  = (m_lives == 0) ? P_OVER : P_RESULT;
        end
      end
      P_RESULT: begin
        m_hold++;
        if (m_hold == HOLD) m_phase = P_ARM;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // ---------------------------------------------------------------- checks
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int s);
    return 8'(((s / 10) * 16) + (s % 10));
  endfunction

  // Every-cycle comparison against the model, well away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("cmp_target",       {4'h0, target},         8'(m_target));
      chk("cmp_target_valid", {7'h0, target_valid},   (m_phase == P_SHOW) ? 8'd1 : 8'd0);
      chk("cmp_score",        score_bcd,              to_bcd(m_score));
      chk("cmp_lives",        {6'h0, lives},          8'(m_lives));
      chk("cmp_hit",          {7'h0, hit_pulse},      8'(m_hit));
      chk("cmp_miss",         {7'h0, miss_pulse},     8'(m_miss));
      chk("cmp_game_over",    {7'h0, game_over},      (m_phase == P_OVER) ? 8'd1 : 8'd0);
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic wait_tv(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!target_valid && n < 40);
    checks++;
    if (!target_valid) begin
      errors++;
      $display("FAIL %s: target_valid still %b after %0d cycles, expected 1", name, target_valid, n);
    end
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic hit_round();
    wait_tv("wait_hit_round");
    press(4'(m_target));
  endtask

  int cnt;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_target",       {4'h0, target},       8'h00);
    chk("rst_target_valid", {7'h0, target_valid}, 8'h00);
    chk("rst_score",        score_bcd,            8'h00);
    chk("rst_lives",        {6'h0, lives},        8'h00);
    chk("rst_pulses",       {6'h0, hit_pulse, miss_pulse}, 8'h00);
    chk("rst_game_over",    {7'h0, game_over},    8'h00);
    @(negedge clk);
    rstn = 1'b1;

    // Start with rand 5: ARM one cycle, then target 5 lit.
    @(negedge clk);
    rand_num = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_arm_tv", {7'h0, target_valid}, 8'h00);
    @(negedge clk);
    chk("start_tv",     {7'h0, target_valid}, 8'h01);
    chk("start_target", {4'h0, target},       8'h05);
    chk("start_lives",  {6'h0, lives},        8'h03);
    chk("start_score",  score_bcd,            8'h00);

    // Hit on the 3rd SHOW cycle, stray key in RESULT, re-entry after hold.
    @(negedge clk);
    press(4'd5);
    chk("hit_pulse",    {7'h0, hit_pulse},    8'h01);
    chk("hit_score",    score_bcd,            8'h01);
    chk("hit_tv_low",   {7'h0, target_valid}, 8'h00);
    press(4'd6);
    repeat (2) @(negedge clk);
    chk("hold_tv_low",  {7'h0, target_valid}, 8'h00);
    @(negedge clk);
    chk("reshow_tv",     {7'h0, target_valid}, 8'h01);
    chk("reshow_target", {4'h0, target},       8'h06);

    // Build up previous target 9, then rand 9 must give target 1.
    rand_num = 8'd9;
    press(4'd6);
    wait_tv("wait_t9");
    chk("target_9", {4'h0, target}, 8'h09);
    press(4'd9);
    wait_tv("wait_t1");
    chk("target_wrap_1", {4'h0, target}, 8'h01);
    press(4'd1);

    // Unusable random values keep the round in ARM; start is ignored there.
    rand_num = 8'd0;
    repeat (8) @(negedge clk);
    pulse_start();
    chk("arm_zero_tv", {7'h0, target_valid}, 8'h00);
    rand_num = 8'h1A;
    repeat (5) @(negedge clk);
    chk("arm_1a_tv",     {7'h0, target_valid}, 8'h00);
    chk("arm_1a_target", {4'h0, target},       8'h00);

    // Timeout: window lasts exactly WIN cycles, then a miss.
    rand_num = 8'd7;
    wait_tv("wait_timeout");
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (target_valid) cnt++;
      else break;
    end
    chk("timeout_len",   8'(cnt),             8'd8);
    chk("timeout_miss",  {7'h0, miss_pulse},  8'h01);
    chk("timeout_lives", {6'h0, lives},       8'h02);

    // Correct key on the expiry cycle is judged instead of the timeout.
    wait_tv("wait_edge_key");
    chk("edge_target", {4'h0, target}, 8'h08);
    repeat (6) @(negedge clk);
    press(4'd8);
    chk("edge_hit",   {7'h0, hit_pulse},  8'h01);
    chk("edge_nomis", {7'h0, miss_pulse}, 8'h00);
    chk("edge_lives", {6'h0, lives},      8'h02);
    chk("edge_score", score_bcd,          8'h05);

    // Two wrong keys finish the game; score holds in OVER.
    wait_tv("wait_wrong1");
    press(4'd2);
    chk("wrong1_lives", {6'h0, lives}, 8'h01);
    wait_tv("wait_wrong2");
    press(4'd2);
    chk("over_lives", {6'h0, lives},     8'h00);
    chk("over_flag",  {7'h0, game_over}, 8'h01);
    press(4'd3);
    repeat (4) @(negedge clk);
    chk("over_score_hold", score_bcd,          8'h05);
    chk("over_flag_hold",  {7'h0, game_over},  8'h01);
    pulse_start();
    chk("restart_lives", {6'h0, lives},     8'h03);
    chk("restart_score", score_bcd,         8'h00);
    chk("restart_over",  {7'h0, game_over}, 8'h00);

    // Score carry 09 -> 10 and saturation at 99.
    rand_num = 8'd3;
    repeat (9) hit_round();
    chk("score_09", score_bcd, 8'h09);
    hit_round();
    chk("score_10", score_bcd, 8'h10);
    repeat (89) hit_round();
    chk("score_99", score_bcd, 8'h99);
    hit_round();
    chk("score_sat",     score_bcd,         8'h99);
    chk("score_sat_hit", {7'h0, hit_pulse}, 8'h01);

    // Three wrong keys against target 7/8: lives 3,2,1,0.
    rand_num = 8'd7;
    for (int i = 0; i < 3; i++) begin
      wait_tv("wait_wrong_seq");
      press(4'd2);
      chk("wrong_seq_lives", {6'h0, lives}, 8'(2 - i));
    end
    chk("wrong_seq_over",  {7'h0, game_over}, 8'h01);
    chk("wrong_seq_score", score_bcd,         8'h99);
    pulse_start();
    chk("restart2_lives", {6'h0, lives}, 8'h03);
    chk("restart2_score", score_bcd,     8'h00);

    // Asynchronous reset in the middle of SHOW.
    wait_tv("wait_mid_reset");
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mrst_target", {4'h0, target},       8'h00);
    chk("mrst_tv",     {7'h0, target_valid}, 8'h00);
    chk("mrst_score",  score_bcd,            8'h00);
    chk("mrst_lives",  {6'h0, lives},        8'h00);
    chk("mrst_over",   {7'h0, game_over},    8'h00);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/whack_target_judge.md
# whack_target_judge

Round controller for the arcade whack-a-target game. It consumes the 1..9 value published by the pseudo-random source and presents it as the lit target. It then judges the player's keypad press within a time window and maintains a BCD score and remaining lives for the 7-segment and LED drivers. It sits between the random source, the keypad decoder and the display logic.

## Interface
Parameters:
- WINDOW_CYCLES, default 50_000_000: cycles a target stays lit before timeout (≥2).
- HOLD_CYCLES, default 25_000_000: cycles the result is shown before the next round (≥1).
- START_LIVES, default 3: lives loaded at game start (1..3).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle start request.
- rand_num  in  8  random value from the random source; valid only when 1..9.
- key_valid  in  1  single-cycle keypad strobe.
- key_code  in  4  pressed key, 1..9; sampled only with key_valid.
- target  out  4  lit target number; 0 when none.
- target_valid  out  1  target lit, window running.
- score_bcd  out  8  two-digit BCD score, {tens, ones}.
- lives  out  2  remaining lives.
- hit_pulse  out  1  one-cycle hit indication.
- miss_pulse  out  1  one-cycle miss (wrong key or timeout).
- game_over  out  1  high while in OVER.

## Operation
- States: IDLE, ARM, SHOW, RESULT, OVER.
- Reset: state IDLE; target=0; target_valid=0; score_bcd=8'h00; lives=0; hit_pulse=0; miss_pulse=0; game_over=0; prev_target=0; counter=0.
- IDLE: start → ARM. On the same edge, score_bcd←00 and lives←START_LIVES.
- ARM: rand_num is usable only if rand_num[7:4]==0 and rand_num[3:0] is in 1..9. Otherwise remain in ARM.
  - Usable value v: cand = (v==prev_target) ? (v==9 ? 1 : v+1) : v.
  - Then target←cand, prev_target←cand, counter←0, target_valid←1, state→SHOW.
- SHOW: counter increments each cycle.
  - key_valid and key_code==target → hit.
  - key_valid and key_code!=target → miss.
  - No key and counter==WINDOW_CYCLES-1 → miss (timeout).
  - key_valid on the expiry cycle: the key is judged and the timeout is ignored.
- Hit: BCD increment. The ones digit wraps 9→0 with a carry into tens. The score saturates at 99 (99 + hit = 99). hit_pulse=1.
- Miss: lives←lives-1 and miss_pulse=1.
- Exiting SHOW on any judgement: target_valid←0, target←0, counter←0.
  - State→OVER if the miss leaves lives==0.
  - Otherwise state→RESULT.
- RESULT: count HOLD_CYCLES, then →ARM. key_valid is ignored.
- OVER: game_over=1; score and lives hold. start → ARM, with score cleared and lives reloaded. prev_target keeps its value.
- start is ignored in ARM, SHOW and RESULT.
- key_valid is ignored outside SHOW.
- Async reset mid-round immediately forces all reset values, including clearing the pulses.

## Timing
- All outputs are registered.
- Judgement on edge N: target_valid falls, the pulse rises and score/lives update, all after edge N. The pulse lasts exactly one cycle.
- A hit or miss in SHOW exits after at most WINDOW_CYCLES cycles in SHOW.
- Timeout with no key: target_valid is high for exactly WINDOW_CYCLES cycles.
- RESULT lasts exactly HOLD_CYCLES cycles. ARM→SHOW takes 1 cycle when rand_num is usable.
- start→ARM takes 1 cycle, so the earliest target_valid is 2 cycles after the start edge.

## Test plan
All scenarios use WINDOW_CYCLES=8, HOLD_CYCLES=4 and START_LIVES=3.
- Reset then start with rand_num=5 → target=5 and target_valid high 2 cycles after start; lives=3; score_bcd=00.
- Target 5, key_valid with key_code=5 on the 3rd SHOW cycle → hit_pulse for 1 cycle; score_bcd=01; target_valid low; SHOW re-entered after 4 RESULT cycles.
- Previous target 9, rand_num=9 → target=1. Then rand_num=0 or 8'h1A held → stays in ARM with target_valid=0.
- No key → target_valid high for 8 cycles, then miss_pulse and lives 3→2. A key arriving on the 8th cycle is judged instead of the timeout.
- Three consecutive wrong keys (key_code=2 against target 7) → lives 3,2,1,0; game_over=1; score holds; start → lives=3, score_bcd=00.
- Score preloaded to 09 then hit → 10. Score at 99 then hit → stays 99 with hit_pulse still asserted. Reset asserted mid-SHOW → all outputs take their reset values immediately.
